// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU operand/select/result bus and debug read port of
// the ALU sequencer. The sequencer uses the slave view; the instruction
// source, ALU and debug logic use the master view.
interface alu_sequencer_if #(
  parameter int unsigned DATA_W = 3
);

  // Instruction handshake
  logic              instr_valid;
  logic              instr_ready;
  logic [8:0]        instr;

  // ALU side: operands, one-hot select, shared result bus
  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] q;
  logic [6:0]        math_out;
  logic [DATA_W-1:0] g;

  // Status
  logic [DATA_W-1:0] result;
  logic              done;
  logic              div_zero_err;

  // Register file debug read
  logic [1:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  instr_valid,
    input  instr,
    input  g,
    input  dbg_addr,
    output instr_ready,
    output p,
    output q,
    output math_out,
    output result,
    output done,
    output div_zero_err,
    output dbg_data
  );

  modport master (
    output instr_valid,
    output instr,
    output g,
    output dbg_addr,
    input  instr_ready,
    input  p,
    input  q,
    input  math_out,
    input  result,
    input  done,
    input  div_zero_err,
    input  dbg_data
  );

endinterface

// File: rtl/alu_sequencer.sv
// Control unit sequencing the shared 3-bit ALU: accepts one instruction per
// handshake, reads two operands from a 4x3 register file, drives p/q and the
// one-hot math_out select for SETTLE_CYCLES cycles, samples the result bus g
// and writes it back.
// Optional feature macro: ALU_OP_COUNT_EN adds an 8-bit saturating op_count
// output counting completed writes.
module alu_sequencer #(
  parameter int unsigned DATA_W        = 3,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_sequencer_if.slave bus
`ifdef ALU_OP_COUNT_EN
  ,
  output logic [7:0]     op_count
`endif
);

  localparam logic [2:0] OpXor   = 3'd0;
  localparam logic [2:0] OpAdd   = 3'd1;
  localparam logic [2:0] OpSub   = 3'd2;
  localparam logic [2:0] OpAnd   = 3'd3;
  localparam logic [2:0] OpOr    = 3'd4;
  localparam logic [2:0] OpDiv   = 3'd5;
  localparam logic [2:0] OpMod   = 3'd6;
  localparam logic [2:0] OpLoadi = 3'd7;

  // Last value of the exec counter before leaving EXEC.
  localparam logic [2:0] ExecLast = 3'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StOper,
    StExec,
    StWb
  } state_e;

  state_e            state_q;
  logic [8:0]        instr_q;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] p_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] result_q;
  logic [6:0]        math_out_q;
  logic              done_q;
  logic              div_zero_err_q;
  logic [2:0]        exec_cnt_q;

  logic [2:0]        op;
  logic [1:0]        dst;
  logic [1:0]        src_a;
  logic [1:0]        src_b;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] wb_val;
  logic              div_by_zero;

  // Field decode of the latched instruction.
  assign op     = instr_q[8:6];
  assign dst    = instr_q[5:4];
  assign src_a  = instr_q[3:2];
  assign src_b  = instr_q[1:0];
  assign imm    = instr_q[DATA_W-1:0];
  assign wb_val = (op == OpLoadi) ? imm : res_q;

  // DIV/MOD with a zero divisor must never enable the ALU.
  assign div_by_zero = ((op == OpDiv) || (op == OpMod)) && (regs_q[src_b] == '0);

  // Op field to ALU select; LOADI never reaches EXEC so it maps to no driver.
  function automatic logic [6:0] op_onehot(input logic [2:0] o);
    logic [6:0] sel;
    sel = 7'b0000000;
    case (o)
      OpXor:   sel = 7'b1000000;
      OpAdd:   sel = 7'b0100000;
      OpSub:   sel = 7'b0010000;
      OpAnd:   sel = 7'b0001000;
      OpOr:    sel = 7'b0000100;
      OpDiv:   sel = 7'b0000010;
      OpMod:   sel = 7'b0000001;
      default: sel = 7'b0000000;
    endcase
    return sel;
  endfunction

  // Sequencer FSM with registered outputs and register file write-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      instr_q        <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
      p_q            <= '0;
      q_q            <= '0;
      res_q          <= '0;
      result_q       <= '0;
      math_out_q     <= '0;
      done_q         <= 1'b0;
      div_zero_err_q <= 1'b0;
      exec_cnt_q     <= '0;
    end else begin
      done_q         <= 1'b0;
      div_zero_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state_q <= StOper;
          end
        end
        StOper: begin
          // Operands are read here, ahead of this instruction's own write-back.
          p_q        <= regs_q[src_a];
          q_q        <= regs_q[src_b];
          exec_cnt_q <= '0;
          if (op == OpLoadi) begin
            state_q <= StWb;
          end else if (div_by_zero) begin
            div_zero_err_q <= 1'b1;
            state_q        <= StIdle;
          end else begin
            math_out_q <= op_onehot(op);
            state_q    <= StExec;
          end
        end
        StExec: begin
          if (exec_cnt_q == ExecLast) begin
            res_q      <= bus.g;
            math_out_q <= '0;
            state_q    <= StWb;
          end else begin
            exec_cnt_q <= exec_cnt_q + 3'd1;
          end
        end
        StWb: begin
          regs_q[dst] <= wb_val;
          result_q    <= wb_val;
          done_q      <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_OP_COUNT_EN
  logic [7:0] op_count_q;

  // Saturating count of completed write-backs; aborted ops never pulse done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count_q <= '0;
    end else if (done_q && (op_count_q != 8'hff)) begin
      op_count_q <= op_count_q + 8'd1;
    end
  end

  assign op_count = op_count_q;
`endif

  assign bus.instr_ready  = (state_q == StIdle);
  assign bus.p            = p_q;
  assign bus.q            = q_q;
  assign bus.math_out     = math_out_q;
  assign bus.result       = result_q;
  assign bus.done         = done_q;
  assign bus.div_zero_err = div_zero_err_q;
  assign bus.dbg_data     = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one default instance and one with
// SETTLE_CYCLES=3, each fed by a small behavioural ALU model on g.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer_if a_if ();
  alu_sequencer_if b_if ();

`ifdef ALU_OP_COUNT_EN
  logic [7:0] op_count_a;
  logic [7:0] op_count_b;
`endif

  alu_sequencer u_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (a_if.slave)
`ifdef ALU_OP_COUNT_EN
    ,
    .op_count (op_count_a)
`endif
  );

  alu_sequencer #(
    .SETTLE_CYCLES (3)
  ) u_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (b_if.slave)
`ifdef ALU_OP_COUNT_EN
    ,
    .op_count (op_count_b)
`endif
  );

  // Behavioural ALU: selected unit drives g, nothing selected reads as 0.
  function automatic logic [2:0] alu_model(input logic [2:0] x, input logic [2:0] y,
                                           input logic [6:0] sel);
    case (sel)
      7'b1000000: return x ^ y;
      7'b0100000: return x + y;
      7'b0010000: return x - y;
      7'b0001000: return x & y;
      7'b0000100: return x | y;
      7'b0000010: return (y != 3'd0) ? x / y : 3'd0;
      7'b0000001: return (y != 3'd0) ? x % y : 3'd0;
      default:    return 3'd0;
    endcase
  endfunction

  assign a_if.g = alu_model(a_if.p, a_if.q, a_if.math_out);
  assign b_if.g = alu_model(b_if.p, b_if.q, b_if.math_out);

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] dst,
                                    input logic [1:0] sa, input logic [1:0] sb);
    return {op, dst, sa, sb};
  endfunction

  function automatic logic [8:0] loadi(input logic [1:0] dst, input logic [2:0] imm);
    return {3'd7, dst, 1'b0, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_a(input string tag, input logic [1:0] addr, input logic [2:0] exp);
    a_if.dbg_addr = addr;
    #1;
    check(tag, 32'(a_if.dbg_data), 32'(exp));
  endtask

  // Present an instruction for exactly one accepting edge; leaves DUT in OPER.
  task automatic issue_a(input logic [8:0] ins);
    check("a_ready_at_accept", 32'(a_if.instr_ready), 32'd1);
    a_if.instr       = ins;
    a_if.instr_valid = 1'b1;
    tick();
    a_if.instr_valid = 1'b0;
    check("a_busy_after_accept", 32'(a_if.instr_ready), 32'd0);
  endtask

  task automatic run_loadi_a(input logic [1:0] dst, input logic [2:0] imm);
    issue_a(loadi(dst, imm));
    check("loadi_oper_sel", 32'(a_if.math_out), 32'd0);
    tick();
    check("loadi_wb_sel", 32'(a_if.math_out), 32'd0);
    check("loadi_wb_done", 32'(a_if.done), 32'd0);
    tick();
    check("loadi_done_at_2", 32'(a_if.done), 32'd1);
    check("loadi_result", 32'(a_if.result), 32'(imm));
    tick();
    check("loadi_done_one_cycle", 32'(a_if.done), 32'd0);
    dbg_a("loadi_reg", dst, imm);
  endtask

  task automatic run_alu_a(input string name, input logic [8:0] ins, input logic [6:0] sel,
                           input logic [2:0] ep, input logic [2:0] eq, input logic [2:0] eres);
    issue_a(ins);
    check({name, "_oper_sel"}, 32'(a_if.math_out), 32'd0);
    tick();
    check({name, "_exec_sel"}, 32'(a_if.math_out), 32'(sel));
    check({name, "_p"}, 32'(a_if.p), 32'(ep));
    check({name, "_q"}, 32'(a_if.q), 32'(eq));
    tick();
    check({name, "_wb_sel"}, 32'(a_if.math_out), 32'd0);
    check({name, "_wb_done"}, 32'(a_if.done), 32'd0);
    tick();
    check({name, "_done_at_3"}, 32'(a_if.done), 32'd1);
    check({name, "_result"}, 32'(a_if.result), 32'(eres));
    tick();
    check({name, "_done_one_cycle"}, 32'(a_if.done), 32'd0);
    dbg_a({name, "_reg"}, ins[5:4], eres);
  endtask

  task automatic issue_b(input logic [8:0] ins);
    b_if.instr       = ins;
    b_if.instr_valid = 1'b1;
    tick();
    b_if.instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int run;
    int runs;
    int dones;

    rst_a_n          = 1'b0;
    rst_b_n          = 1'b0;
    a_if.instr_valid = 1'b0;
    a_if.instr       = '0;
    a_if.dbg_addr    = '0;
    b_if.instr_valid = 1'b0;
    b_if.instr       = '0;
    b_if.dbg_addr    = '0;
    tick();
    tick();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    tick();

    // Reset state
    check("rst_ready", 32'(a_if.instr_ready), 32'd1);
    check("rst_math_out", 32'(a_if.math_out), 32'd0);
    check("rst_done", 32'(a_if.done), 32'd0);
    check("rst_div_zero_err", 32'(a_if.div_zero_err), 32'd0);
    check("rst_result", 32'(a_if.result), 32'd0);
    check("rst_p", 32'(a_if.p), 32'd0);
    check("rst_q", 32'(a_if.q), 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_a("rst_reg", 2'(i), 3'd0);
    end

    // Immediates, then each ALU op with hand-computed results
    run_loadi_a(2'd1, 3'd5);
    run_loadi_a(2'd2, 3'd3);
    run_alu_a("add_wrap", mk(3'd1, 2'd0, 2'd1, 2'd2), 7'b0100000, 3'd5, 3'd3, 3'd0);
    run_alu_a("sub_wrap", mk(3'd2, 2'd0, 2'd2, 2'd1), 7'b0010000, 3'd3, 3'd5, 3'd6);
    run_alu_a("and",      mk(3'd3, 2'd2, 2'd1, 2'd0), 7'b0001000, 3'd5, 3'd6, 3'd4);
    run_loadi_a(2'd1, 3'd6);
    run_loadi_a(2'd2, 3'd2);
    run_alu_a("div",      mk(3'd5, 2'd3, 2'd1, 2'd2), 7'b0000010, 3'd6, 3'd2, 3'd3);
    run_loadi_a(2'd1, 3'd2);
    run_alu_a("mod_dst_is_src", mk(3'd6, 2'd3, 2'd3, 2'd1), 7'b0000001, 3'd3, 3'd2, 3'd1);
    run_alu_a("or",       mk(3'd4, 2'd0, 2'd3, 2'd1), 7'b0000100, 3'd1, 3'd2, 3'd3);
    run_loadi_a(2'd2, 3'd0);

    // DIV by zero aborts: error pulse, no ALU enable, no write, no done
    issue_a(mk(3'd5, 2'd3, 2'd1, 2'd2));
    check("dz_oper_sel", 32'(a_if.math_out), 32'd0);
    tick();
    check("dz_err_pulse", 32'(a_if.div_zero_err), 32'd1);
    check("dz_ready_back", 32'(a_if.instr_ready), 32'd1);
    check("dz_sel", 32'(a_if.math_out), 32'd0);
    check("dz_no_done", 32'(a_if.done), 32'd0);
    tick();
    check("dz_err_one_cycle", 32'(a_if.div_zero_err), 32'd0);
    check("dz_no_done_later", 32'(a_if.done), 32'd0);
    check("dz_sel_later", 32'(a_if.math_out), 32'd0);
    dbg_a("dz_dst_unchanged", 2'd3, 3'd1);
`ifdef ALU_OP_COUNT_EN
    check("a_op_count_no_abort", 32'(op_count_a), 32'd12);
`endif

    // SETTLE_CYCLES=3: LOADI r1=5, r2=6, then three back-to-back XORs
    issue_b(loadi(2'd1, 3'd5));
    tick();
    tick();
    check("b_loadi1_done", 32'(b_if.done), 32'd1);
    issue_b(loadi(2'd2, 3'd6));
    tick();
    tick();
    check("b_loadi2_result", 32'(b_if.result), 32'd6);
    b_if.instr       = mk(3'd0, 2'd0, 2'd1, 2'd2);
    b_if.instr_valid = 1'b1;
    run   = 0;
    runs  = 0;
    dones = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (b_if.done) dones++;
      if (b_if.math_out != 7'd0) begin
        check("b_xor_sel", 32'(b_if.math_out), 32'h40);
        run++;
      end else if (run != 0) begin
        check("b_xor_settle_len", 32'(run), 32'd3);
        runs++;
        run = 0;
      end
    end
    b_if.instr_valid = 1'b0;
    check("b_xor_runs", 32'(runs), 32'd3);
    check("b_xor_dones", 32'(dones), 32'd3);
    check("b_xor_result", 32'(b_if.result), 32'd3);
    b_if.dbg_addr = 2'd0;
    #1;
    check("b_xor_reg", 32'(b_if.dbg_data), 32'd3);
`ifdef ALU_OP_COUNT_EN
    check("b_op_count_5", 32'(op_count_b), 32'd5);
    b_if.instr       = loadi(2'd3, 3'd7);
    b_if.instr_valid = 1'b1;
    repeat (900) tick();
    b_if.instr_valid = 1'b0;
    tick();
    tick();
    check("b_op_count_saturate", 32'(op_count_b), 32'd255);
`endif

    // Reset in the middle of EXEC of an ADD
    issue_a(mk(3'd1, 2'd0, 2'd1, 2'd3));
    tick();
    check("mid_exec_sel", 32'(a_if.math_out), 32'h20);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(a_if.math_out), 32'd0);
    check("async_rst_ready", 32'(a_if.instr_ready), 32'd1);
    tick();
    rst_a_n = 1'b1;
    tick();
    check("post_rst_done", 32'(a_if.done), 32'd0);
    check("post_rst_ready", 32'(a_if.instr_ready), 32'd1);
    check("post_rst_result", 32'(a_if.result), 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_a("post_rst_reg", 2'(i), 3'd0);
    end
    tick();
    check("post_rst_no_done", 32'(a_if.done), 32'd0);
`ifdef ALU_OP_COUNT_EN
    check("post_rst_op_count", 32'(op_count_a), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
